// File: rtl/jc2_decoder.sv
// Receive-side decoder for a bidirectional Johnson counter: tracks position, direction, stalls and code errors.
// Optional build macro JC2_DEC_STEPCNT_EN adds the signed net step counter on step_cnt.
module jc2_decoder #(
    parameter int WIDTH     = 4,
    parameter int STALL_CYC = 8,
    localparam int PW       = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q,
    output logic [PW-1:0]    pos,
    output logic             pos_valid,
    output logic             dir,
    output logic             step,
    output logic             stopped,
    output logic             ill_err,
    output logic             skip_err,
    output logic [7:0]       err_cnt,
    output logic [15:0]      step_cnt
);

    localparam logic [0:0]  ST_INIT  = 1'b0;
    localparam logic [0:0]  ST_TRACK = 1'b1;
    localparam logic [PW:0] TWO_W    = (PW + 1)'(2 * WIDTH);
    localparam logic [15:0] STALL_MAX = 16'(STALL_CYC);

    logic [0:0]       state;
    logic [WIDTH-1:0] qS;
    logic [15:0]      stallCnt;
    logic [15:0]      stallNext;
    logic [PW:0]      onesCnt;
    logic [PW:0]      transCnt;
    logic [PW:0]      delta;
    logic [PW-1:0]    posCur;
    logic             legal;
    logic             isTrack;
    logic             stepFwd;
    logic             stepBack;
    logic             stepSkip;
    logic             hold;

    // pos_valid is the FSM state itself, so the state is always observable on the ports.
    assign pos_valid = (state == ST_TRACK);

    always_comb begin
        onesCnt  = '0;
        transCnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onesCnt = onesCnt + (PW + 1)'(qS[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            transCnt = transCnt + (PW + 1)'(qS[i] ^ qS[i+1]);
        end
        legal  = (transCnt <= (PW + 1)'(1));
        posCur = qS[WIDTH-1] ? PW'(TWO_W - onesCnt) : PW'(onesCnt);
        // Modular difference keeps the 2*WIDTH-1 <-> 0 wrap a plain single step.
        delta = {1'b0, posCur} + TWO_W - {1'b0, pos};
        if (delta >= TWO_W) begin
            delta = delta - TWO_W;
        end
        isTrack   = (state == ST_TRACK);
        hold      = legal && isTrack && (delta == '0);
        stepFwd   = legal && isTrack && (delta == (PW + 1)'(1));
        stepBack  = legal && isTrack && (delta == TWO_W - (PW + 1)'(1));
        stepSkip  = legal && isTrack && !hold && !stepFwd && !stepBack;
        stallNext = (stallCnt == STALL_MAX) ? stallCnt : stallCnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            qS       <= '0;
            pos      <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            stopped  <= 1'b0;
            ill_err  <= 1'b0;
            skip_err <= 1'b0;
            err_cnt  <= '0;
            stallCnt <= '0;
        end else begin
            qS       <= q;
            step     <= 1'b0;
            ill_err  <= 1'b0;
            skip_err <= 1'b0;
            if (!legal || stepSkip) begin
                err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            end
            if (!legal) begin
                ill_err  <= 1'b1;
                state    <= ST_INIT;
                stopped  <= 1'b0;
                stallCnt <= '0;
            end else if (!isTrack) begin
                pos   <= posCur;
                state <= ST_TRACK;
            end else if (hold) begin
                stallCnt <= stallNext;
                stopped  <= (stallNext == STALL_MAX);
            end else if (stepFwd || stepBack) begin
                pos      <= posCur;
                dir      <= stepFwd;
                step     <= 1'b1;
                stallCnt <= '0;
                stopped  <= 1'b0;
            end else begin
                skip_err <= 1'b1;
                pos      <= posCur;
            end
        end
    end

`ifdef JC2_DEC_STEPCNT_EN
    logic [15:0] stepCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stepCnt <= '0;
        end else if (stepFwd) begin
            stepCnt <= stepCnt + 16'd1;
        end else if (stepBack) begin
            stepCnt <= stepCnt - 16'd1;
        end
    end

    assign step_cnt = stepCnt;
`else
    assign step_cnt = 16'd0;
`endif

endmodule
